// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: rebuilds 640x480@60 raster position from sync edges.
// Optional frame CRC outputs are enabled by defining VGA_MON_CRC_EN.
module vga_sync_monitor #(
    parameter int HS_ACTIVE    = 0,
    parameter int VS_ACTIVE    = 0,
    parameter int LOCK_FRAMES  = 2,
    parameter int RGB_LAG      = 1,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        pixel_clk,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [11:0] rgb,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_count
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic       HS_LVL = 1'(HS_ACTIVE);
    localparam logic       VS_LVL = 1'(VS_ACTIVE);
    localparam logic [3:0] LF     = 4'(LOCK_FRAMES);
    localparam logic [9:0] HV     = 10'(H_VISIBLE);
    localparam logic [9:0] HSS    = 10'(H_SYNC_START);
    localparam logic [9:0] HSE    = 10'(H_SYNC_END);
    localparam logic [9:0] HLAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] VV     = 10'(V_VISIBLE);
    localparam logic [9:0] VSS    = 10'(V_SYNC_START);
    localparam logic [9:0] VSE    = 10'(V_SYNC_END);
    localparam logic [9:0] VLAST  = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] h, v;
    logic [9:0] cur_h, cur_v, h_next, v_next;
    logic       h_al, v_al, h_al_nxt, v_al_nxt;
    logic [3:0] good, good_nxt;
    logic       hs_prev, vs_prev;
    logic       hs_now, vs_now, hs_edge, vs_edge;
    logic       h_wrap, v_wrap, hs_exp, vs_exp, mismatch;
    logic       lose, present;
    logic [9:0] ph [3];
    logic [9:0] pv [3];
    logic [9:0] dh, dv;

    assign hs_now  = (h_sync == HS_LVL);
    assign vs_now  = (v_sync == VS_LVL);
    assign hs_edge = hs_now & ~hs_prev;
    assign vs_edge = vs_now & ~vs_prev;

    // Position of this tick: sync edges realign it only while searching.
    always_comb begin
        cur_h = h;
        cur_v = v;
        if (state == SEARCH && hs_edge) cur_h = HSS;
        if (state == SEARCH && vs_edge) cur_v = VSS;
        h_wrap   = (cur_h == HLAST);
        v_wrap   = h_wrap && (cur_v == VLAST);
        h_next   = h_wrap ? 10'd0 : cur_h + 10'd1;
        v_next   = cur_v;
        if (h_wrap) v_next = v_wrap ? 10'd0 : cur_v + 10'd1;
        hs_exp   = (cur_h >= HSS) && (cur_h < HSE);
        vs_exp   = (cur_v >= VSS) && (cur_v < VSE);
        mismatch = (hs_now != hs_exp) || (vs_now != vs_exp);
    end

    // Lock state machine: next state, alignment flags, good-frame count.
    always_comb begin
        state_nxt = state;
        h_al_nxt  = h_al;
        v_al_nxt  = v_al;
        good_nxt  = good;
        lose      = 1'b0;
        if (pixel_clk) begin
            unique case (state)
                SEARCH: begin
                    if (hs_edge) h_al_nxt = 1'b1;
                    if (vs_edge) v_al_nxt = 1'b1;
                    if (h_al_nxt && v_al_nxt) begin
                        state_nxt = ACQUIRE;
                        good_nxt  = 4'd0;
                    end
                end
                ACQUIRE: begin
                    if (mismatch) begin
                        state_nxt = SEARCH;
                        h_al_nxt  = 1'b0;
                        v_al_nxt  = 1'b0;
                    end else if (v_wrap) begin
                        good_nxt = good + 4'd1;
                        if (good_nxt == LF) state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state_nxt = SEARCH;
                        h_al_nxt  = 1'b0;
                        v_al_nxt  = 1'b0;
                        lose      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    h_al_nxt  = 1'b0;
                    v_al_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Position delayed by RGB_LAG ticks so it lines up with the colour.
    always_comb begin
        dh = cur_h;
        dv = cur_v;
        for (int i = 0; i < 3; i++) begin
            if (RGB_LAG == i + 1) begin
                dh = ph[i];
                dv = pv[i];
            end
        end
    end

    assign present = (state == LOCKED) && (state_nxt == LOCKED);

    // Counters, sync history and delay pipeline advance on ticks only.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state   <= SEARCH;
            h       <= 10'd0;
            v       <= 10'd0;
            h_al    <= 1'b0;
            v_al    <= 1'b0;
            good    <= 4'd0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                ph[i] <= 10'd0;
                pv[i] <= 10'd0;
            end
        end else if (pixel_clk) begin
            state   <= state_nxt;
            h       <= h_next;
            v       <= v_next;
            h_al    <= h_al_nxt;
            v_al    <= v_al_nxt;
            good    <= good_nxt;
            hs_prev <= hs_now;
            vs_prev <= vs_now;
            ph[0]   <= cur_h;
            pv[0]   <= cur_v;
            for (int i = 1; i < 3; i++) begin
                ph[i] <= ph[i-1];
                pv[i] <= pv[i-1];
            end
        end
    end

    // Registered outputs: pixel samples, frame strobe, lock and errors.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 12'd0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (pixel_clk) begin
                locked <= (state_nxt == LOCKED);
                if (present && dh < HV && dv < VV) begin
                    pix_valid <= 1'b1;
                    pix_x     <= dh;
                    pix_y     <= dv;
                    pix_rgb   <= rgb;
                end
                if (present && dh == 10'd0 && dv == 10'd0)
                    frame_start <= 1'b1;
                if (lose) begin
                    sync_err <= 1'b1;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                end
            end
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_run;

    function automatic logic [15:0] crc12(
        input logic [15:0] c,
        input logic [11:0] d
    );
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Running CRC over presented pixels, published at each frame start.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            crc_run   <= 16'hFFFF;
            frame_crc <= 16'd0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (!locked) begin
                crc_run <= 16'hFFFF;
            end else if (frame_start) begin
                frame_crc <= crc_run;
                crc_valid <= 1'b1;
                crc_run   <= pix_valid ? crc12(16'hFFFF, pix_rgb)
                                       : 16'hFFFF;
            end else if (pix_valid) begin
                crc_run <= crc12(crc_run, pix_rgb);
            end
        end
    end
`else
    // Frame CRC not built in this configuration.
`endif

endmodule
